// File: rtl/breg_write_arbiter.sv
// Round-robin arbiter granting one requester at a time a single-cycle write
// into a shared enable-loaded register, followed by a four-phase acknowledge.
module breg_write_arbiter #(
   parameter  int N_REQ = 4,
   parameter  int DW    = 4,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rest,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] wdata,
   output logic [N_REQ-1:0]    ack,
   output logic                reg_en,
   output logic [DW-1:0]       reg_d,
   output logic [IW-1:0]       owner,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     ptr, ptr_nxt;
   logic [IW-1:0]     owner_nxt;
   logic [IW-1:0]     win;
   logic [DW-1:0]     reg_d_nxt;
   logic              reg_en_nxt;
   logic [N_REQ-1:0]  ack_nxt;
   logic              busy_nxt;

   // First set bit of r scanning upward from p with wrap; scanning the
   // offsets in reverse lets the smallest offset overwrite the others.
   function automatic logic [IW-1:0] pick(input logic [N_REQ-1:0] r,
                                          input logic [IW-1:0]    p);
      logic [IW-1:0] w;
      int            idx;
      w = p;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(p) + k) % N_REQ;
         if (r[idx]) w = IW'(idx);
      end
      return w;
   endfunction

   function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
      return (int'(w) == N_REQ - 1) ? '0 : w + 1'b1;
   endfunction

   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      owner_nxt  = owner;
      reg_d_nxt  = reg_d;
      reg_en_nxt = 1'b0;
      ack_nxt    = ack;
      busy_nxt   = busy;
      win        = pick(req, ptr);
      case (state)
         IDLE: begin
            if (|req) begin
               owner_nxt  = win;
               reg_d_nxt  = wdata[int'(win)*DW +: DW];
               reg_en_nxt = 1'b1;
               busy_nxt   = 1'b1;
               ptr_nxt    = next_ptr(win);
               state_nxt  = WRITE;
            end
         end
         WRITE: begin
            // ack is issued even if the owner already withdrew its request
            ack_nxt        = '0;
            ack_nxt[owner] = 1'b1;
            state_nxt      = ACK;
         end
         ACK: begin
            if (!req[owner]) begin
               ack_nxt   = '0;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            ack_nxt   = '0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state  <= IDLE;
         ptr    <= '0;
         owner  <= '0;
         reg_d  <= '0;
         reg_en <= 1'b0;
         ack    <= '0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         ptr    <= ptr_nxt;
         owner  <= owner_nxt;
         reg_d  <= reg_d_nxt;
         reg_en <= reg_en_nxt;
         ack    <= ack_nxt;
         busy   <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_breg_write_arbiter.sv
// Directed bench for breg_write_arbiter: a transaction-level model checked
// every cycle, plus literal expectations for the scenarios of interest.
module tb_breg_write_arbiter;
   localparam int N  = 4;
   localparam int DW = 4;

   logic            clk = 1'b0;
   logic            rest = 1'b0;
   logic [N-1:0]    req;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    ack;
   logic            reg_en;
   logic [DW-1:0]   reg_d;
   logic [1:0]      owner;
   logic            busy;

   breg_write_arbiter #(.N_REQ(N), .DW(DW)) dut (
      .clk(clk), .rest(rest), .req(req), .wdata(wdata),
      .ack(ack), .reg_en(reg_en), .reg_d(reg_d), .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Shared register that the arbiter writes into
   logic [DW-1:0] shreg = '0;
   always @(posedge clk) if (reg_en) shreg <= reg_d;

   // Transaction model: phase 0 idle, 1 write in flight, 2 awaiting release
   int            m_phase, m_ptr, m_owner, m_best, m_win, m_dist;
   logic [N-1:0]  e_ack;
   logic [DW-1:0] e_d;
   logic          e_en, e_busy;

   always @(posedge clk or negedge rest) begin
      if (!rest) begin
         m_phase = 0; m_ptr = 0; m_owner = 0;
         e_ack = '0; e_d = '0; e_en = 1'b0; e_busy = 1'b0;
      end else begin
         e_en = 1'b0;
         if (m_phase == 0 && req != '0) begin
            m_best = N;
            m_win  = 0;
            for (int i = 0; i < N; i++) begin
               m_dist = (i - m_ptr + N) % N;
               if (req[i] && m_dist < m_best) begin
                  m_best = m_dist;
                  m_win  = i;
               end
            end
            m_owner = m_win;
            e_d     = wdata[m_win*DW +: DW];
            e_en    = 1'b1;
            e_busy  = 1'b1;
            m_ptr   = (m_win + 1) % N;
            m_phase = 1;
         end else if (m_phase == 1) begin
            e_ack = N'(1 << m_owner);
            m_phase = 2;
         end else if (m_phase == 2 && !req[m_owner]) begin
            e_ack   = '0;
            e_busy  = 1'b0;
            m_phase = 0;
         end
      end
   end

   logic [1:0]    g_owner[$];
   logic [DW-1:0] g_data[$];

   always @(posedge clk) begin
      #1;
      chk("ack", ack, e_ack);
      chk("reg_en", reg_en, e_en);
      chk("reg_d", reg_d, e_d);
      chk("owner", owner, m_owner[1:0]);
      chk("busy", busy, e_busy);
      if (reg_en) begin
         g_owner.push_back(owner);
         g_data.push_back(reg_d);
      end
   end

   logic [N-1:0] want;

   // Requesters drop req while acked and re-raise once ack clears
   task automatic step_auto();
      @(negedge clk);
      req = want & ~ack;
   endtask

   task automatic wait_grants(input int target, input string name);
      int n = 0;
      while (g_owner.size() < target && n < 60) begin
         step_auto();
         n++;
      end
      chk(name, g_owner.size(), target);
   endtask

   task automatic drain();
      int n = 0;
      want = '0;
      do begin
         step_auto();
         n++;
      end while (busy && n < 20);
      chk("drain_busy", busy, 0);
   endtask

   int base;

   initial begin
      want  = '1;
      req   = '1;
      wdata = {4'h4, 4'h3, 4'h2, 4'h1};
      repeat (2) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_en", reg_en, 0);
      chk("rst_d", reg_d, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      rest = 1'b1;
      @(negedge clk);
      chk("first_en", reg_en, 1);
      chk("first_owner", owner, 0);

      // Round robin with all four requesting
      wait_grants(5, "rr_count");
      chk("rr_o0", g_owner[0], 0); chk("rr_o1", g_owner[1], 1);
      chk("rr_o2", g_owner[2], 2); chk("rr_o3", g_owner[3], 3);
      chk("rr_o4", g_owner[4], 0);
      chk("rr_d0", g_data[0], 4'h1); chk("rr_d1", g_data[1], 4'h2);
      chk("rr_d2", g_data[2], 4'h3); chk("rr_d3", g_data[3], 4'h4);
      chk("rr_d4", g_data[4], 4'h1);
      drain();

      // Single request from requester 2
      wdata[11:8] = 4'hA;
      req = 4'b0100;
      @(negedge clk);
      chk("single_en", reg_en, 1);
      chk("single_d", reg_d, 4'hA);
      chk("single_owner", owner, 2);
      chk("single_ack_early", ack, 0);
      @(negedge clk);
      chk("single_en_off", reg_en, 0);
      chk("single_ack", ack, 4'b0100);
      chk("single_reg", shreg, 4'hA);
      req = '0;
      @(negedge clk);
      chk("single_release_ack", ack, 0);
      chk("single_release_busy", busy, 0);

      // Pointer now at 3: wrap to 0, then 1, then a late requester 3
      base = g_owner.size();
      want = 4'b0011;
      wait_grants(base + 1, "wrap_first");
      want = 4'b1011;
      wait_grants(base + 3, "wrap_count");
      chk("wrap_o0", g_owner[base], 0);
      chk("wrap_o1", g_owner[base+1], 1);
      chk("wrap_o2", g_owner[base+2], 3);
      drain();

      // Owner withdraws during the write: one-cycle ack then idle
      req = 4'b1000;
      @(negedge clk);
      chk("viol_en", reg_en, 1);
      chk("viol_owner", owner, 3);
      req = '0;
      @(negedge clk);
      chk("viol_ack", ack, 4'b1000);
      @(negedge clk);
      chk("viol_ack_clear", ack, 0);
      chk("viol_busy", busy, 0);

      // Data changes during the write are not captured
      wdata[7:4] = 4'h5;
      req = 4'b0010;
      @(negedge clk);
      chk("stab_d", reg_d, 4'h5);
      wdata[7:4] = 4'hF;
      @(negedge clk);
      chk("stab_reg", shreg, 4'h5);
      chk("stab_ack", ack, 4'b0010);

      // Reset in ACK clears outputs at once and restarts the pointer
      rest = 1'b0;
      #1;
      chk("mid_ack", ack, 0);
      chk("mid_busy", busy, 0);
      chk("mid_en", reg_en, 0);
      chk("mid_owner", owner, 0);
      @(negedge clk);
      rest = 1'b1;
      req  = 4'b0110;
      @(negedge clk);
      chk("post_rst_owner", owner, 1);
      chk("post_rst_d", reg_d, 4'hF);
      drain();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
